// File: rtl/arity_bist_sequencer.sv
// arity_bist_sequencer: clocked BIST driver for a small combinational arity block.
// Walks every input vector (MSB of dut_in toggles fastest), holds each for a
// settle window, folds the response into a MISR and compares against a golden
// signature when the walk completes.
// Optional build macro ARITY_BIST_CAPTURE_EN adds an EMIT state that streams
// each (vector, response) pair out over a valid/ready capture port.
//
// state  | meaning
// IDLE   | waiting for start, dut_in parked at 0
// APPLY  | driving the current vector, counting settle cycles
// SAMPLE | fold dut_out into the MISR
// EMIT   | capture beat pending handshake (capture build only)
// DONE   | signature frozen, done/pass valid, start re-runs
module arity_bist_sequencer #(
    parameter int              N_IN          = 3,
    parameter int              N_OUT         = 3,
    parameter int              SETTLE_CYCLES = 2,
    parameter int              SIG_W         = 16,
    parameter logic [SIG_W-1:0] POLY         = 16'h1021,
    parameter logic [SIG_W-1:0] SEED         = 16'hFFFF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic [N_IN-1:0]  o_dut_in,
    input  logic [N_OUT-1:0] i_dut_out,
    input  logic [SIG_W-1:0] i_expected_sig,
    output logic [N_IN-1:0]  o_vec_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [SIG_W-1:0] o_signature,
    output logic             o_cap_valid,
    input  logic             i_cap_ready,
    output logic [N_IN-1:0]  o_cap_vec,
    output logic [N_OUT-1:0] o_cap_resp
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // A one-cycle settle window still needs a 1-bit counter.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [2:0]       r_state;
    logic [N_IN-1:0]  r_vec_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [SIG_W-1:0] r_sig;
    logic [N_IN-1:0]  r_dut_in;

    logic [SIG_W-1:0] w_sig_next;
    logic             w_advance;
    logic             w_last;

    // Bit-reverse the vector index so the top dut_in bit toggles fastest.
    function automatic logic [N_IN-1:0] f_map(input logic [N_IN-1:0] idx);
        logic [N_IN-1:0] m;
        for (int i = 0; i < N_IN; i++) begin
            m[N_IN-1-i] = idx[i];
        end
        return m;
    endfunction

    // MISR next state: shift, polynomial feedback on the outgoing bit, fold response.
    assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(i_dut_out);

    assign w_last = &r_vec_idx;

`ifdef ARITY_BIST_CAPTURE_EN
    logic             r_cap_valid;
    logic [N_IN-1:0]  r_cap_vec;
    logic [N_OUT-1:0] r_cap_resp;

    assign w_advance = (r_state == S_EMIT) && r_cap_valid && i_cap_ready;

    // Capture beat: load on the sample cycle, hold until the consumer takes it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cap_valid <= 1'b0;
            r_cap_vec   <= '0;
            r_cap_resp  <= '0;
        end else if (r_state == S_SAMPLE) begin
            r_cap_valid <= 1'b1;
            r_cap_vec   <= r_dut_in;
            r_cap_resp  <= i_dut_out;
        end else if (r_cap_valid && i_cap_ready) begin
            r_cap_valid <= 1'b0;
        end
    end

    assign o_cap_valid = r_cap_valid;
    assign o_cap_vec   = r_cap_vec;
    assign o_cap_resp  = r_cap_resp;
`else
    logic w_unused_cap_ready;

    assign w_advance          = (r_state == S_SAMPLE);
    assign w_unused_cap_ready = i_cap_ready;
    assign o_cap_valid        = 1'b0;
    assign o_cap_vec          = '0;
    assign o_cap_resp         = '0;
`endif

    // Sequencer FSM: vector walk, settle timing, MISR fold and run restart.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_vec_idx <= '0;
            r_cnt     <= '0;
            r_sig     <= SEED;
            r_dut_in  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state   <= S_APPLY;
                        r_vec_idx <= '0;
                        r_cnt     <= '0;
                        r_sig     <= SEED;
                        r_dut_in  <= f_map('0);
                    end
                end
                S_APPLY: begin
                    if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    r_sig   <= w_sig_next;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Overrides the SAMPLE->EMIT move when no capture stage is built.
            if (w_advance) begin
                if (w_last) begin
                    r_state  <= S_DONE;
                    r_dut_in <= '0;
                end else begin
                    r_state   <= S_APPLY;
                    r_vec_idx <= r_vec_idx + N_IN'(1);
                    r_cnt     <= '0;
                    r_dut_in  <= f_map(r_vec_idx + N_IN'(1));
                end
            end
        end
    end

    assign o_dut_in    = r_dut_in;
    assign o_vec_idx   = r_vec_idx;
    assign o_signature = r_sig;
    assign o_busy      = (r_state == S_APPLY) || (r_state == S_SAMPLE) || (r_state == S_EMIT);
    assign o_done      = (r_state == S_DONE);
    assign o_pass      = o_done && (r_sig == i_expected_sig);

endmodule

// File: tb/tb_arity_bist_sequencer.sv
// Testbench for arity_bist_sequencer: default 3-in instance driven by an
// identity / zero / random-table DUT, plus a 2-in, 1-settle instance.
module tb_arity_bist_sequencer;

`ifdef ARITY_BIST_CAPTURE_EN
    localparam int PER_VEC   = 4;
    localparam int PER_VEC_S = 3;
`else
    localparam int PER_VEC   = 3;
    localparam int PER_VEC_S = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, cap_ready;
    logic [15:0] expected_sig, signature;
    logic [2:0]  dut_in, dut_out, vec_idx, cap_vec, cap_resp;
    logic        busy, done, pass, cap_valid;

    logic        s_start;
    logic [15:0] s_exp, s_sig;
    logic [1:0]  s_dut_in, s_vec_idx, s_cap_vec, s_cap_resp;
    logic        s_busy, s_done, s_pass, s_cap_valid;

    int          mode;
    logic [2:0]  lut [8];
    logic [2:0]  order3 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    logic [1:0]  order2 [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

    int checks = 0;
    int errors = 0;

    always_comb begin
        case (mode)
            0:       dut_out = dut_in;
            1:       dut_out = 3'd0;
            default: dut_out = lut[dut_in];
        endcase
    end

    arity_bist_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .o_dut_in(dut_in), .i_dut_out(dut_out), .i_expected_sig(expected_sig),
        .o_vec_idx(vec_idx), .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_signature(signature), .o_cap_valid(cap_valid), .i_cap_ready(cap_ready),
        .o_cap_vec(cap_vec), .o_cap_resp(cap_resp)
    );

    arity_bist_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE_CYCLES(1)) dut_s (
        .i_clk(clk), .i_reset(reset), .i_start(s_start),
        .o_dut_in(s_dut_in), .i_dut_out(s_dut_in), .i_expected_sig(s_exp),
        .o_vec_idx(s_vec_idx), .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass),
        .o_signature(s_sig), .o_cap_valid(s_cap_valid), .i_cap_ready(1'b1),
        .o_cap_vec(s_cap_vec), .o_cap_resp(s_cap_resp)
    );

    // MISR as polynomial arithmetic: multiply by x, reduce mod x^16+0x1021, add response.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] r);
        int v;
        v = int'(s) * 2;
        if (v >= 65536) v = v ^ 'h11021;
        v = v ^ int'(r);
        return v[15:0];
    endfunction

    // Expected signature of the default instance for the current DUT mode.
    function automatic logic [15:0] model_sig(input int m);
        logic [15:0] s;
        logic [2:0]  r;
        s = 16'hFFFF;
        for (int k = 0; k < 8; k++) begin
            if (m == 0)      r = order3[k];
            else if (m == 1) r = 3'd0;
            else             r = lut[order3[k]];
            s = misr_step(s, {13'd0, r});
        end
        return s;
    endfunction

    task automatic go();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit to);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        to = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; s_start = 1'b0; cap_ready = 1'b1;
        mode = 0; expected_sig = 16'hE0CD; s_exp = 16'h0000;
        for (int v = 0; v < 8; v++) lut[v] = 3'(v);
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
        checks++; if (dut_in !== 3'd0) begin errors++; $display("FAIL reset_dut_in got %0d want 0", dut_in); end
        checks++; if (vec_idx !== 3'd0) begin errors++; $display("FAIL reset_vec_idx got %0d want 0", vec_idx); end
        checks++; if (signature !== 16'hFFFF) begin errors++; $display("FAIL reset_sig got %h want ffff", signature); end
        checks++; if ({cap_valid, cap_vec, cap_resp} !== 7'd0) begin errors++; $display("FAIL reset_cap got %b/%0d/%0d want 0", cap_valid, cap_vec, cap_resp); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_identity();
        mode = 0; expected_sig = 16'hE0CD;
        go();
        for (int t = 0; t < 8 * PER_VEC; t++) begin
            checks++;
            if (dut_in !== order3[t / PER_VEC] || vec_idx !== 3'(t / PER_VEC) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL ident_seq t=%0d got dut_in=%0d idx=%0d busy=%b done=%b want dut_in=%0d idx=%0d busy=1 done=0",
                         t, dut_in, vec_idx, busy, done, order3[t / PER_VEC], t / PER_VEC);
            end
            @(posedge clk); #1;
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ident_done got done=%b busy=%b want 1/0", done, busy); end
        checks++; if (dut_in !== 3'd0) begin errors++; $display("FAIL ident_dut_in_idle got %0d want 0", dut_in); end
        checks++; if (signature !== 16'hE0CD) begin errors++; $display("FAIL ident_sig got %h want e0cd", signature); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ident_pass got %b want 1", pass); end
    endtask

    task automatic test_const_zero();
        int n; bit to;
        mode = 1; expected_sig = 16'hE0CD;
        go();
        wait_done(n, to);
        checks++; if (to || n != 8 * PER_VEC) begin errors++; $display("FAIL zero_latency got %0d edges (timeout=%b) want %0d", n, to, 8 * PER_VEC); end
        checks++; if (signature !== 16'hE1F0) begin errors++; $display("FAIL zero_sig got %h want e1f0", signature); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL zero_pass got %b want 0", pass); end
    endtask

    task automatic test_random();
        int n; bit to;
        logic [15:0] exp_m;
        for (int it = 0; it < 4; it++) begin
            for (int v = 0; v < 8; v++) lut[v] = 3'($urandom_range(0, 7));
            mode  = 2;
            exp_m = model_sig(2);
            expected_sig = ($urandom_range(0, 1) == 1) ? exp_m : (exp_m ^ 16'(1 << $urandom_range(0, 15)));
            go();
            wait_done(n, to);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout it=%0d got busy=%b want done", it, busy); end
            checks++; if (signature !== exp_m) begin errors++; $display("FAIL rand_sig it=%0d got %h want %h", it, signature, exp_m); end
            checks++; if (pass !== (expected_sig == exp_m)) begin errors++; $display("FAIL rand_pass it=%0d got %b want %b", it, pass, expected_sig == exp_m); end
            repeat (3) @(posedge clk);
            #1;
            checks++; if (signature !== exp_m || done !== 1'b1) begin errors++; $display("FAIL rand_frozen it=%0d got %h done=%b want %h done=1", it, signature, done, exp_m); end
        end
    endtask

    task automatic test_reset_midrun();
        int n; bit to;
        mode = 0; expected_sig = 16'hE0CD;
        go();
        repeat (3 * PER_VEC + 1) @(posedge clk);
        #1;
        checks++; if (vec_idx !== 3'd3) begin errors++; $display("FAIL mid_vec got %0d want 3", vec_idx); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL mid_abort got busy=%b done=%b pass=%b want 0", busy, done, pass); end
        checks++; if (dut_in !== 3'd0 || vec_idx !== 3'd0) begin errors++; $display("FAIL mid_clear got dut_in=%0d idx=%0d want 0", dut_in, vec_idx); end
        checks++; if (signature !== 16'hFFFF) begin errors++; $display("FAIL mid_sig got %h want ffff", signature); end
        @(negedge clk);
        reset = 1'b0;
        go();
        wait_done(n, to);
        checks++; if (to || signature !== 16'hE0CD) begin errors++; $display("FAIL mid_rerun got %h (timeout=%b) want e0cd", signature, to); end
    endtask

    task automatic test_start_held();
        mode = 0; expected_sig = 16'hE0CD;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        repeat (8 * PER_VEC) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1 || signature !== 16'hE0CD) begin errors++; $display("FAIL held_first got done=%b sig=%h want 1/e0cd", done, signature); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || signature !== 16'hFFFF || vec_idx !== 3'd0) begin
            errors++; $display("FAIL held_restart got busy=%b done=%b sig=%h idx=%0d want 1/0/ffff/0", busy, done, signature, vec_idx);
        end
        for (int c = 1; c <= 8 * PER_VEC; c++) begin
            @(negedge clk);
            start = (c < 10) ? 1'(c % 2) : 1'b0;
            @(posedge clk); #1;
            if (c == 8 * PER_VEC - 1) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL held_early got done=%b want 0", done); end
            end
        end
        start = 1'b0;
        checks++; if (done !== 1'b1 || signature !== 16'hE0CD) begin errors++; $display("FAIL held_second got done=%b sig=%h want 1/e0cd", done, signature); end
    endtask

    task automatic test_small();
        logic [15:0] exp_s;
        exp_s = 16'hFFFF;
        for (int k = 0; k < 4; k++) exp_s = misr_step(exp_s, {14'd0, order2[k]});
        s_exp = exp_s;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int t = 0; t < 4 * PER_VEC_S; t++) begin
            checks++;
            if (s_dut_in !== order2[t / PER_VEC_S] || s_busy !== 1'b1) begin
                errors++; $display("FAIL small_seq t=%0d got %0d busy=%b want %0d busy=1", t, s_dut_in, s_busy, order2[t / PER_VEC_S]);
            end
            @(posedge clk); #1;
        end
        checks++; if (s_done !== 1'b1 || s_sig !== exp_s || s_pass !== 1'b1) begin
            errors++; $display("FAIL small_done got done=%b sig=%h pass=%b want 1/%h/1", s_done, s_sig, s_pass, exp_s);
        end
    endtask

`ifdef ARITY_BIST_CAPTURE_EN
    task automatic test_capture();
        int n; bit to;
        mode = 0; expected_sig = 16'hE0CD; cap_ready = 1'b0;
        go();
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!cap_valid && n < 50) begin @(posedge clk); #1; n++; end
            checks++; if (cap_valid !== 1'b1 || cap_vec !== order3[k] || cap_resp !== order3[k]) begin
                errors++; $display("FAIL cap_beat k=%0d got v=%b vec=%0d resp=%0d want 1/%0d/%0d", k, cap_valid, cap_vec, cap_resp, order3[k], order3[k]);
            end
            repeat (5) begin
                @(posedge clk); #1;
                checks++; if (cap_valid !== 1'b1 || cap_vec !== order3[k] || cap_resp !== order3[k]) begin
                    errors++; $display("FAIL cap_stall k=%0d got v=%b vec=%0d resp=%0d want 1/%0d/%0d", k, cap_valid, cap_vec, cap_resp, order3[k], order3[k]);
                end
            end
            @(negedge clk);
            cap_ready = 1'b1;
            @(posedge clk); #1;
            cap_ready = 1'b0;
            checks++; if (cap_valid !== 1'b0) begin errors++; $display("FAIL cap_drop k=%0d got %b want 0", k, cap_valid); end
        end
        wait_done(n, to);
        checks++; if (to || signature !== 16'hE0CD || pass !== 1'b1) begin
            errors++; $display("FAIL cap_sig got %h pass=%b (timeout=%b) want e0cd/1", signature, pass, to);
        end
        cap_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_const_zero();
        test_random();
        test_reset_midrun();
        test_start_held();
        test_small();
`ifdef ARITY_BIST_CAPTURE_EN
        test_capture();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
